// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the tx path now and the rx path later.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Unused upper payload bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_e mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: reloads on restart, ticks in the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart || cnt == '0)
      cnt <= LOAD;
    else
      cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding buffer so frames can
// be sent back to back with no idle gap between stop and the next start bit.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 idle,
  output logic                 frame_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam parity_e PMODE = parity_e'(PARITY_MODE[1:0]);

  tx_state_e               state_q, state_d;
  logic                    buf_full_q;
  logic [DATA_BITS-1:0]    buf_data_q;
  logic [DATA_BITS-1:0]    shreg_q, shreg_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    restart, tick, drain, start_frame, accept;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign accept   = tx_valid && !buf_full_q;
  assign tx_ready = !buf_full_q;
  assign idle     = (state_q == ST_IDLE) && !buf_full_q;
  assign tx       = tx_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    par_d       = par_q;
    tx_d        = tx_q;
    restart     = 1'b0;
    drain       = 1'b0;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (buf_full_q) start_frame = 1'b1;
      end
      ST_START: if (tick) begin
        state_d = ST_DATA;
        idx_d   = '0;
        restart = 1'b1;
        tx_d    = shreg_q[0];
      end
      ST_DATA: if (tick) begin
        restart = 1'b1;
        if (idx_q == LAST_DATA) begin
          idx_d = '0;
          if (PMODE == PAR_NONE) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
        end
      end
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        idx_d   = '0;
        restart = 1'b1;
        tx_d    = 1'b1;
      end
      ST_STOP: if (tick) begin
        if (idx_q == LAST_STOP) begin
          frame_done = 1'b1;
          if (buf_full_q) start_frame = 1'b1;
          else            state_d     = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pending word starts its frame on the very next edge, from IDLE or STOP.
    if (start_frame) begin
      drain   = 1'b1;
      shreg_d = buf_data_q;
      par_d   = calc_parity(MAX_DATA_BITS'(buf_data_q), PMODE);
      state_d = ST_START;
      restart = 1'b1;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if (accept)     buf_full_q <= 1'b1;
      else if (drain) buf_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
    if (accept) buf_data_q <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at CLKS_PER_BIT=4 across four configurations.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8N1
  logic [7:0] a_data = '0;
  logic a_valid = 1'b0, a_ready, a_tx, a_idle, a_done;
  // 8E1
  logic [7:0] e_data = '0;
  logic e_valid = 1'b0, e_ready, e_tx, e_idle, e_done;
  // 8O1
  logic [7:0] o_data = '0;
  logic o_valid = 1'b0, o_ready, o_tx, o_idle, o_done;
  // 7N2
  logic [6:0] s_data = '0;
  logic s_valid = 1'b0, s_ready, s_tx, s_idle, s_done;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx(a_tx), .idle(a_idle), .frame_done(a_done));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(e_data), .tx_valid(e_valid),
    .tx_ready(e_ready), .tx(e_tx), .idle(e_idle), .frame_done(e_done));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready), .tx(o_tx), .idle(o_idle), .frame_done(o_done));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx(s_tx), .idle(s_idle), .frame_done(s_done));

  task automatic test_reset();
    logic [6:0] obs;
    repeat (20) begin
      @(negedge clk);
      obs = {a_tx, a_idle, a_ready, a_done, e_tx, o_tx, s_tx};
      n_cmp++;
      if (obs !== 7'b1110111) begin
        n_err++;
        $display("FAIL por tx/idle/ready/done/e/o/s got %b want 1110111", obs);
      end
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      obs = {a_tx, a_idle, a_ready, a_done, e_idle, o_idle, s_idle};
      n_cmp++;
      if (obs !== 7'b1110111) begin
        n_err++;
        $display("FAIL post_por got %b want 1110111", obs);
      end
    end
  endtask

  task automatic test_8n1();
    // 0xA5 frame, first bit in bit 0: start 0, 1,0,1,0,0,1,0,1, stop 1
    logic [9:0] f = 10'b1101001010;
    logic [2:0] o3;
    logic [1:0] obs, exp2;
    @(negedge clk); a_data = 8'hA5; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0; a_data = 8'h00;
    o3 = {a_tx, a_idle, a_ready};
    n_cmp++;
    if (o3 !== 3'b100) begin
      n_err++;
      $display("FAIL 8n1_accept tx/idle/ready got %b want 100", o3);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs = {a_tx, a_done};
      exp2 = {f[k/4], (k == 39)};
      n_cmp++;
      if (obs !== exp2) begin
        n_err++;
        $display("FAIL 8n1 k=%0d tx/done got %b want %b", k, obs, exp2);
      end
    end
    @(negedge clk);
    o3 = {a_tx, a_idle, a_ready};
    n_cmp++;
    if (o3 !== 3'b111) begin
      n_err++;
      $display("FAIL 8n1_end tx/idle/ready got %b want 111", o3);
    end
  endtask

  task automatic test_parity();
    // 0x55: start 0, 1,0,1,0,1,0,1,0, parity, stop 1
    logic [10:0] fe = 11'b10010101010;
    logic [10:0] fo = 11'b11010101010;
    logic [3:0] obs, exp4;
    @(negedge clk); e_data = 8'h55; o_data = 8'h55; e_valid = 1'b1; o_valid = 1'b1;
    @(negedge clk); e_valid = 1'b0; o_valid = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      obs = {e_tx, e_done, o_tx, o_done};
      exp4 = {fe[k/4], (k == 43), fo[k/4], (k == 43)};
      n_cmp++;
      if (obs !== exp4) begin
        n_err++;
        $display("FAIL parity k=%0d even tx/done odd tx/done got %b want %b", k, obs, exp4);
      end
    end
    @(negedge clk);
    obs = {e_tx, e_idle, o_tx, o_idle};
    n_cmp++;
    if (obs !== 4'b1111) begin
      n_err++;
      $display("FAIL parity_end tx/idle got %b want 1111", obs);
    end
  endtask

  task automatic test_back_to_back();
    // 0x00 frame (bits 9..0) then 0xFF frame (bits 19..10), no gap
    logic [19:0] f = {10'b1111111110, 10'b1000000000};
    logic [2:0] obs, exp3;
    @(negedge clk); a_data = 8'h00; a_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full ready got %b want 0", a_ready);
    end
    a_data = 8'hFF;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      obs = {a_tx, a_ready, a_done};
      exp3 = {f[k/4], (k == 0 || k >= 40), (k == 39 || k == 79)};
      n_cmp++;
      if (obs !== exp3) begin
        n_err++;
        $display("FAIL b2b k=%0d tx/ready/done got %b want %b", k, obs, exp3);
      end
      if (k == 1) begin
        a_valid = 1'b0;
        a_data = 8'h5A;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_tx, a_idle} !== 2'b11) begin
      n_err++;
      $display("FAIL b2b_end tx/idle got %b want 11", {a_tx, a_idle});
    end
  endtask

  task automatic test_7n2();
    // 0x7F, 7 bits: start 0, seven 1s, two stop 1s
    logic [9:0] f = 10'b1111111110;
    logic [1:0] obs, exp2;
    @(negedge clk); s_data = 7'h7F; s_valid = 1'b1;
    @(negedge clk); s_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs = {s_tx, s_done};
      exp2 = {f[k/4], (k == 39)};
      n_cmp++;
      if (obs !== exp2) begin
        n_err++;
        $display("FAIL 7n2 k=%0d tx/done got %b want %b", k, obs, exp2);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({s_tx, s_idle, s_done} !== 3'b110) begin
      n_err++;
      $display("FAIL 7n2_end tx/idle/done got %b want 110", {s_tx, s_idle, s_done});
    end
  endtask

  task automatic test_reset_mid();
    // 0x3C: start 0, 0,0,1,1,1,1,0,0, stop 1
    logic [9:0] f = 10'b1001111000;
    logic [3:0] o4;
    logic [1:0] obs, exp2;
    @(negedge clk); a_data = 8'h00; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_tx !== 1'b0) begin
        n_err++;
        $display("FAIL mid_pre k=%0d tx got %b want 0", k, a_tx);
      end
    end
    // k=17 is inside data bit 3
    rst_n = 1'b0;
    #1;
    o4 = {a_tx, a_idle, a_ready, a_done};
    n_cmp++;
    if (o4 !== 4'b1110) begin
      n_err++;
      $display("FAIL mid_rst tx/idle/ready/done got %b want 1110", o4);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      o4 = {a_tx, a_idle, a_ready, a_done};
      n_cmp++;
      if (o4 !== 4'b1110) begin
        n_err++;
        $display("FAIL mid_after tx/idle/ready/done got %b want 1110", o4);
      end
    end
    @(negedge clk); a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      obs = {a_tx, a_done};
      exp2 = {f[k/4], (k == 39)};
      n_cmp++;
      if (obs !== exp2) begin
        n_err++;
        $display("FAIL mid_3c k=%0d tx/done got %b want %b", k, obs, exp2);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_tx, a_idle} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_end tx/idle got %b want 11", {a_tx, a_idle});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_7n2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
